// File: rtl/seg7_pkg.sv
// seg7_pkg: shared types, glyph table and helpers for the seven-segment hex scanner.
// The helper first_nibble is used only when SEG7_LZ_SKIP_EN is defined.
package seg7_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned NIB_W  = 4;
  localparam int unsigned IDX_W  = 3;
  localparam int unsigned SEG_W  = 7;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DIGIT = 2'd1,
    GAP   = 2'd2
  } state_e;

  // Hex glyphs packed {g,f,e,d,c,b,a}, indexed by nibble value
  localparam logic [SEG_W-1:0] GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // Index of the most significant nonzero nibble; 0 for an all-zero word
  function automatic logic [IDX_W-1:0] first_nibble(input logic [WORD_W-1:0] d);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      if (d[4*i +: 4] != 4'h0) r = IDX_W'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/seg7_hex_scanner_if.sv
// seg7_hex_scanner_if: valid/ready write channel from the core to the display back-end.
interface seg7_hex_scanner_if;
  import seg7_pkg::*;

  logic  wr_valid;
  logic  wr_ready;
  word_t wr_data;

  modport master (output wr_valid, output wr_data, input  wr_ready);
  modport slave  (input  wr_valid, input  wr_data, output wr_ready);

endinterface

// File: rtl/seg7_hex_decode.sv
// seg7_hex_decode: combinational nibble to seven-segment glyph lookup.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [NIB_W-1:0] nib_i,
  output logic [SEG_W-1:0] glyph_o
);

  // Table lookup
  assign glyph_o = GLYPH[nib_i];

endmodule

// File: rtl/seg7_hex_scanner.sv
// seg7_hex_scanner: one-entry shadow buffer feeding a nibble-by-nibble scan of a
// single seven-segment digit, with a blank gap between digits.
// Optional build macro SEG7_LZ_SKIP_EN: frames start at the highest nonzero nibble.
module seg7_hex_scanner
  import seg7_pkg::*;
#(
  parameter int unsigned DWELL_CYCLES = 12_000_000,
  parameter int unsigned GAP_CYCLES   = 3_000_000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  seg7_hex_scanner_if.slave  bus,
  output logic [SEG_W-1:0]   segments,
  output logic               dp,
  output logic               busy
);

  localparam int unsigned MAX_CYC = (DWELL_CYCLES > GAP_CYCLES) ? DWELL_CYCLES : GAP_CYCLES;
  localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  word_t            disp_q, disp_d;
  word_t            shadow_q, shadow_d;
  logic             shadow_full_q, shadow_full_d;
  logic [SEG_W-1:0] segments_d;
  logic             dp_d, busy_d;
  logic             load_c, accept_c;
  logic [IDX_W-1:0] start_shadow_c, start_disp_c, start_next_c;
  logic [SEG_W-1:0] glyph_c;

  assign bus.wr_ready = !shadow_full_q;
  assign accept_c     = bus.wr_valid && !shadow_full_q;

`ifdef SEG7_LZ_SKIP_EN
  assign start_shadow_c = first_nibble(shadow_q);
  assign start_disp_c   = first_nibble(disp_q);
  assign start_next_c   = first_nibble(disp_d);
`else
  assign start_shadow_c = IDX_W'(7);
  assign start_disp_c   = IDX_W'(7);
  assign start_next_c   = IDX_W'(7);
`endif

  seg7_hex_decode u_decode (
    .nib_i   (disp_d[{idx_d, 2'b00} +: NIB_W]),
    .glyph_o (glyph_c)
  );

  // Next-state, shadow buffer and output decode from the upcoming state
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    disp_d        = disp_q;
    shadow_d      = shadow_q;
    shadow_full_d = shadow_full_q;
    load_c        = 1'b0;

    if (ena) begin
      unique case (state_q)
        IDLE: begin
          if (shadow_full_q) begin
            load_c  = 1'b1;
            disp_d  = shadow_q;
            idx_d   = start_shadow_c;
            cnt_d   = '0;
            state_d = DIGIT;
          end
        end
        DIGIT: begin
          if (cnt_q == DWELL_LAST) begin
            cnt_d   = '0;
            state_d = GAP;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        GAP: begin
          if (cnt_q == GAP_LAST) begin
            cnt_d   = '0;
            state_d = DIGIT;
            if (idx_q != IDX_W'(0)) begin
              idx_d = idx_q - IDX_W'(1);
            end else if (shadow_full_q) begin
              load_c = 1'b1;
              disp_d = shadow_q;
              idx_d  = start_shadow_c;
            end else begin
              idx_d = start_disp_c;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // A load and an accept can never coincide: accept needs the buffer empty
    if (load_c)   shadow_full_d = 1'b0;
    if (accept_c) begin
      shadow_d      = bus.wr_data;
      shadow_full_d = 1'b1;
    end

    segments_d = '0;
    dp_d       = 1'b0;
    busy_d     = 1'b0;
    if (ena) begin
      busy_d = (state_d != IDLE);
      if (state_d == DIGIT) begin
        segments_d = glyph_c;
        dp_d       = (idx_d == start_next_c);
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      idx_q         <= IDX_W'(7);
      disp_q        <= '0;
      shadow_q      <= '0;
      shadow_full_q <= 1'b0;
      segments      <= '0;
      dp            <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      disp_q        <= disp_d;
      shadow_q      <= shadow_d;
      shadow_full_q <= shadow_full_d;
      segments      <= segments_d;
      dp            <= dp_d;
      busy          <= busy_d;
    end
  end

endmodule

// File: tb/tb_seg7_hex_scanner.sv
// tb_seg7_hex_scanner: directed bench for seg7_hex_scanner with DWELL=4, GAP=2.
// Build with SEG7_LZ_SKIP_EN defined to also cover leading-zero skipping.
module tb_seg7_hex_scanner;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [6:0] segments;
  logic       dp;
  logic       busy;

  int n_checks;
  int n_errors;

  logic [6:0] exp_g [8];

  seg7_hex_scanner_if bus ();

  seg7_hex_scanner #(
    .DWELL_CYCLES (4),
    .GAP_CYCLES   (2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .bus      (bus.slave),
    .segments (segments),
    .dp       (dp),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.wr_valid = 1'b0;
    bus.wr_data  = '0;
    ena = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Present a word for one edge; returns sampled just after the accepting edge
  task automatic write_word(input logic [31:0] w);
    bus.wr_valid = 1'b1;
    bus.wr_data  = w;
    tick();
    bus.wr_valid = 1'b0;
  endtask

  // Check n digits of a frame starting at the current sample, then the restart
  task automatic check_frame(input int n, input string tag);
    for (int c = 0; c < 6*n; c++) begin
      int pos;
      int nib;
      pos = c % 6;
      nib = c / 6;
      check({tag, "_seg"}, 32'(segments), (pos < 4) ? 32'(exp_g[nib]) : 32'h0);
      check({tag, "_dp"},  32'(dp), (pos < 4 && nib == 0) ? 32'h1 : 32'h0);
      tick();
    end
    check({tag, "_repeat"}, 32'(segments), 32'(exp_g[0]));
    check({tag, "_repeat_dp"}, 32'(dp), 32'h1);
  endtask

  initial begin
    int lit;
    int stray;
    n_checks = 0;
    n_errors = 0;
    bus.wr_valid = 1'b0;
    bus.wr_data  = '0;
    ena   = 1'b1;
    rst_n = 1'b0;
    #2;
    check("rst_ready", 32'(bus.wr_ready), 32'h1);

    // Reset and idle
    do_reset();
    repeat (10) tick();
    check("idle_seg",   32'(segments), 32'h0);
    check("idle_dp",    32'(dp), 32'h0);
    check("idle_busy",  32'(busy), 32'h0);
    check("idle_ready", 32'(bus.wr_ready), 32'h1);

    // Basic frame of 0x1234ABCD
    write_word(32'h1234ABCD);
    check("acc_ready", 32'(bus.wr_ready), 32'h0);
    check("acc_seg",   32'(segments), 32'h0);
    tick();
    check("first_busy",  32'(busy), 32'h1);
    check("first_ready", 32'(bus.wr_ready), 32'h1);
    exp_g = '{7'h06, 7'h5B, 7'h4F, 7'h66, 7'h77, 7'h7C, 7'h39, 7'h5E};
    check_frame(8, "frame1234");

    // Back-to-back writes: second waits for the frame end
    do_reset();
    bus.wr_valid = 1'b1;
    bus.wr_data  = 32'h11111111;
    tick();
    bus.wr_data  = 32'hFFFFFFFF;
    tick();
    for (int c = 0; c < 48; c++) begin
      check("b2b_seg", 32'(segments), ((c % 6) < 4) ? 32'h06 : 32'h0);
      check("b2b_ready", 32'(bus.wr_ready), (c == 0) ? 32'h1 : 32'h0);
      if (c == 1) bus.wr_valid = 1'b0;
      tick();
    end
    check("b2b_new_seg",   32'(segments), 32'h71);
    check("b2b_new_dp",    32'(dp), 32'h1);
    check("b2b_new_ready", 32'(bus.wr_ready), 32'h1);

    // ena freeze mid-DIGIT
    do_reset();
    write_word(32'h1234ABCD);
    tick();
    lit = 0;
    check("ena_first", 32'(segments), 32'h06);
    if (segments != 0) lit++;
    tick();
    if (segments != 0) lit++;
    ena = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      check("ena_off_seg",  32'(segments), 32'h0);
      check("ena_off_busy", 32'(busy), 32'h0);
      if (segments != 0) lit++;
    end
    ena = 1'b1;
    tick();
    check("ena_resume_seg",  32'(segments), 32'h06);
    check("ena_resume_busy", 32'(busy), 32'h1);
    if (segments != 0) lit++;
    tick();
    check("ena_last_seg", 32'(segments), 32'h06);
    if (segments != 0) lit++;
    tick();
    check("ena_gap_seg", 32'(segments), 32'h0);
    check("ena_lit_total", 32'(lit), 32'd4);
    tick();
    tick();
    check("ena_next_seg", 32'(segments), 32'h5B);
    check("ena_next_dp",  32'(dp), 32'h0);

    // Reset mid-GAP with a pending word
    do_reset();
    write_word(32'h1234ABCD);
    tick();
    write_word(32'h55555555);
    check("rstg_pending", 32'(bus.wr_ready), 32'h0);
    repeat (3) tick();
    check("rstg_in_gap", 32'(segments), 32'h0);
    check("rstg_busy_pre", 32'(busy), 32'h1);
    rst_n = 1'b0;
    #1;
    check("rstg_seg",   32'(segments), 32'h0);
    check("rstg_dp",    32'(dp), 32'h0);
    check("rstg_busy",  32'(busy), 32'h0);
    check("rstg_ready", 32'(bus.wr_ready), 32'h1);
    tick();
    rst_n = 1'b1;
    stray = 0;
    for (int c = 0; c < 60; c++) begin
      tick();
      if (segments != 0 || busy != 0) stray++;
    end
    check("rstg_no_pending", 32'(stray), 32'd0);

`ifdef SEG7_LZ_SKIP_EN
    // Leading-zero skip
    do_reset();
    write_word(32'h000000A5);
    tick();
    exp_g = '{7'h77, 7'h6D, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};
    check_frame(2, "lz_a5");
    do_reset();
    write_word(32'h00000000);
    tick();
    exp_g = '{7'h3F, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};
    check_frame(1, "lz_zero");
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/seg7_hex_scanner.md
# seg7_hex_scanner

Display back-end of `tt_um_pkuligowski_top`. It takes 32-bit result words from the RISC-V test core over a valid/ready handshake, holds them in a one-entry shadow buffer, and scans them nibble by nibble onto the single seven-segment digit on `uo_out[6:0]`. Each frame shows nibbles 7 down to 0 with a blank gap between digits, so repeated digits stay distinguishable. The frame repeats until a new word arrives.

## Interface
- `DWELL_CYCLES`, default 12_000_000: cycles each nibble is lit; must be ≥ 1.
- `GAP_CYCLES`, default 3_000_000: blank cycles after each nibble; must be ≥ 1.
- `clk` in 1: single clock domain.
- `rst_n` in 1: asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `ena` in 1: design-select. When low, the scan freezes and the display blanks.
- `wr_valid` in 1: the core presents a word.
- `wr_ready` out 1: the shadow buffer is empty. Combinational, equal to `!shadow_full`.
- `wr_data` in 32: word to display.
- `segments` out 7: active-high; bit 0 = a … bit 6 = g; registered.
- `dp` out 1: decimal point; lit while nibble 7 is shown (frame marker); registered.
- `busy` out 1: the state is not IDLE; registered.

## Operation
- A write is accepted on a rising edge with `wr_valid && wr_ready`. At that edge `wr_data` goes into `shadow` and `shadow_full` is set.
- FSM states:
  - IDLE
    - Outputs are blank.
    - If `shadow_full`: load `disp <= shadow`, clear `shadow_full`, set `idx <= 7` (or the first nibble, see Configuration), clear the counter, go to DIGIT.
  - DIGIT
    - `segments = hex(disp[4*idx+:4])`; `dp = (idx==7)`.
    - When the counter reaches `DWELL_CYCLES-1`, go to GAP and clear the counter.
  - GAP
    - `segments = 0`; `dp = 0`.
    - When the counter reaches `GAP_CYCLES-1`:
      - If `idx != 0`: `idx <= idx-1`, go to DIGIT.
      - If `idx == 0` (frame end): if `shadow_full`, load a new `disp` and clear `shadow_full`; restart at the first nibble in DIGIT. With no new word, the same value repeats.
- After the first word the FSM never returns to IDLE; only reset brings it back.
- A new word waits in `shadow` until the current frame ends. Frames are never torn.
- `wr_ready` stays low from the acceptance edge until the edge that moves the word out of `shadow`. It rises in the cycle after that edge.
- Hex glyphs, a..g bit-packed {g..a}: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
- `ena` low:
  - State, counter, `idx` and `disp` hold.
  - `segments`, `dp` and `busy` go to 0 at the next edge.
  - Handshake acceptance continues.
  - When `ena` returns high, the scan resumes with the same counter value.

## Timing
- Reset (asynchronous assert): state IDLE, `segments=0`, `dp=0`, `busy=0`, `shadow_full=0` so `wr_ready=1`, `idx=7`, counter 0, `disp=0`.
- Latency: word accepted at edge E0 → FSM leaves IDLE at E1 → the first glyph is on `segments` after E1, i.e. 2 edges after acceptance.
- Each DIGIT lasts exactly `DWELL_CYCLES` cycles; each GAP lasts exactly `GAP_CYCLES` cycles. A full frame lasts 8·(DWELL+GAP) cycles.
- The counter is `$clog2(max(DWELL,GAP))` bits wide. It is compared for equality only and never wraps past its limit.
- A write in the same cycle as the frame-end load is impossible, because `wr_ready` is 0 while `shadow_full`.
- Reset mid-frame: the display blanks immediately and any pending shadow word is discarded.

## Configuration
- `SEG7_LZ_SKIP_EN`
  - Defined: each frame starts at the highest nonzero nibble of `disp`; leading zeros are not shown. `disp==0` shows nibble 0 only. `dp` marks the first shown nibble.
  - Undefined: every frame starts at nibble 7 and all 8 nibbles are shown.

## Structure
- `seg7_pkg`:
  - state enum `{IDLE, DIGIT, GAP}`
  - 16-entry glyph constant table
  - function `first_nibble(logic [31:0])` used under `SEG7_LZ_SKIP_EN`
- Sub-module `seg7_hex_decode`: combinational nibble→7-bit glyph lookup using the package table, instantiated once.

## Test plan
All scenarios use DWELL=4, GAP=2.
- Reset, then idle 10 cycles → `segments=0`, `dp=0`, `busy=0`, `wr_ready=1`.
- Write 0x1234ABCD → 2 edges later `segments=06` with `dp=1` for 4 cycles, then 0 for 2 cycles. Sequence continues 5B 4F 66 77 7C 39 5E, then repeats from 06.
- Write 0x11111111; a second write 0xFFFFFFFF in the next cycle → `wr_ready=0` until the first frame ends (48 cycles after the first glyph). Then `71` is shown with no torn frame.
- Deassert `ena` for 5 cycles mid-DIGIT → outputs 0 during that time. On resume the remaining dwell completes, with total lit cycles for that nibble = 4.
- Assert `rst_n` low mid-GAP with a word pending → outputs 0 immediately, `wr_ready=1`, the pending word never appears.
- With `SEG7_LZ_SKIP_EN`, write 0x000000A5 → frame is `77`(dp=1), `6D`, repeat; write 0 → frame is `3F`(dp=1) only.
